id_ex_stage: RTL



---
 rtl/id_ex_stage_pkg.sv | 42 ++++
 rtl/id_ex_stage_if.sv | 79 +++++++
 rtl/id_ex_stage_hazard_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 116 +++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared decode/execute definitions: datapath widths, opcodes, control-word layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;

  // Bubble counter width and its saturation value
  localparam int             CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Opcode space; TYPEA is the multi-cycle (mult/div) class
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_STORE = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_JUMP  = 4'b0101;
  localparam logic [3:0] OP_TYPEA = 4'b1111;

  // Control-word bit ordering, MSB first; control, id_ex_stage and later stages share it
  typedef struct packed {
    logic       multiDiv;
    logic [3:0] opcode;
    logic       aluBType;
    logic       aluSrc;
    logic       signExtendFlag;
    logic       memRead;
    logic       memToReg;
    logic       memWrite;
    logic [1:0] aluControl;
    logic [1:0] regWrite;
    logic [1:0] jumpBranch;
  } ctrl_t;

  // An invalid slot carries no side-effecting control bits
  function automatic ctrl_t ctrlGate(input ctrl_t c, input logic valid);
    return valid ? c : '0;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decoded instruction in, execute-stage view and stall request out.
// Latency: n/a (wiring only).
// Backpressure: stallIn/flush flow toward the stage, stallOut flows back upstream.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) ();

  // Decode side
  logic              idValid;
  logic [3:0]        opcode;
  logic              multiDiv;
  logic              aluBType;
  logic              aluSrc;
  logic              signExtendFlag;
  logic              memRead;
  logic              memToReg;
  logic              memWrite;
  logic [1:0]        aluControl;
  logic [1:0]        regWrite;
  logic [1:0]        jumpBranch;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic [REG_W-1:0]  rd;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] immExt;
  logic [DATA_W-1:0] pc;
  logic              stallIn;
  logic              flush;

  // Execute side
  logic              exValid;
  logic [3:0]        exOpcode;
  logic              exMultiDiv;
  logic              exAluBType;
  logic              exAluSrc;
  logic              exSignExtendFlag;
  logic              exMemRead;
  logic              exMemToReg;
  logic              exMemWrite;
  logic [1:0]        exAluControl;
  logic [1:0]        exRegWrite;
  logic [1:0]        exJumpBranch;
  logic [REG_W-1:0]  exRs1;
  logic [REG_W-1:0]  exRs2;
  logic [REG_W-1:0]  exRd;
  logic [DATA_W-1:0] exReadData1;
  logic [DATA_W-1:0] exReadData2;
  logic [DATA_W-1:0] exImmExt;
  logic [DATA_W-1:0] exPc;
  logic              stallOut;
  logic [CNT_W-1:0]  bubbleCount;

  // Upstream view: drives the decoded instruction, observes execute state
  modport master (
    output idValid, opcode, multiDiv, aluBType, aluSrc, signExtendFlag,
           memRead, memToReg, memWrite, aluControl, regWrite, jumpBranch,
           rs1, rs2, rd, readData1, readData2, immExt, pc, stallIn, flush,
    input  exValid, exOpcode, exMultiDiv, exAluBType, exAluSrc, exSignExtendFlag,
           exMemRead, exMemToReg, exMemWrite, exAluControl, exRegWrite, exJumpBranch,
           exRs1, exRs2, exRd, exReadData1, exReadData2, exImmExt, exPc,
           stallOut, bubbleCount
  );

  // Stage view
  modport slave (
    input  idValid, opcode, multiDiv, aluBType, aluSrc, signExtendFlag,
           memRead, memToReg, memWrite, aluControl, regWrite, jumpBranch,
           rs1, rs2, rd, readData1, readData2, immExt, pc, stallIn, flush,
    output exValid, exOpcode, exMultiDiv, exAluBType, exAluSrc, exSignExtendFlag,
           exMemRead, exMemToReg, exMemWrite, exAluControl, exRegWrite, exJumpBranch,
           exRs1, exRs2, exRd, exReadData1, exReadData2, exImmExt, exPc,
           stallOut, bubbleCount
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard: decode reads a register that the load now in execute will write.
// Latency: 0 cycles, purely combinational.
// Backpressure: none here; the caller turns hazard into a bubble plus an upstream hold.
module hazard_detect #(
  parameter int REG_W = 4
) (
  input  logic             idValid,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             aluSrc,
  input  logic             memWrite,
  input  logic             exValid,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exRd,
  output logic             hazard
);

  // rs2 only matters when it feeds the ALU or supplies store data; r0 is an ordinary register
  logic useRs2;
  assign useRs2 = ~aluSrc | memWrite;
  assign hazard = idValid & exValid & exMemRead &
                  ((exRd == rs1) | (useRs2 & (exRd == rs2)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and saturating bubble counter.
// Latency: 1 cycle decode -> ex*; stallOut is combinational.
// Backpressure: stallIn holds the stage; hazard/stallIn raise stallOut unless flush kills the slot.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  ctrl_t             idCtrl;
  ctrl_t             exCtrl;
  logic              exValid;
  logic [REG_W-1:0]  exRs1;
  logic [REG_W-1:0]  exRs2;
  logic [REG_W-1:0]  exRd;
  logic [DATA_W-1:0] exReadData1;
  logic [DATA_W-1:0] exReadData2;
  logic [DATA_W-1:0] exImmExt;
  logic [DATA_W-1:0] exPc;
  logic [CNT_W-1:0]  bubbleCnt;
  logic              hazard;
  logic              hazardBubble;
  logic              loadBubble;

  assign idCtrl = '{
    multiDiv:       bus.multiDiv,
    opcode:         bus.opcode,
    aluBType:       bus.aluBType,
    aluSrc:         bus.aluSrc,
    signExtendFlag: bus.signExtendFlag,
    memRead:        bus.memRead,
    memToReg:       bus.memToReg,
    memWrite:       bus.memWrite,
    aluControl:     bus.aluControl,
    regWrite:       bus.regWrite,
    jumpBranch:     bus.jumpBranch
  };

  hazard_detect #(.REG_W(REG_W)) uHazard (
    .idValid   (bus.idValid),
    .rs1       (bus.rs1),
    .rs2       (bus.rs2),
    .aluSrc    (bus.aluSrc),
    .memWrite  (bus.memWrite),
    .exValid   (exValid),
    .exMemRead (exCtrl.memRead),
    .exRd      (exRd),
    .hazard    (hazard)
  );

  // A hazard only costs a bubble when execute is free to advance and no flush overrides it
  assign hazardBubble = ~bus.flush & ~bus.stallIn & hazard;
  assign loadBubble   = rst | bus.flush | hazardBubble;
  assign bus.stallOut = ~bus.flush & (bus.stallIn | hazard);

  // Pipeline register: bubble on reset/flush/hazard, hold on stall, otherwise load decode
  always_ff @(posedge clk) begin
    if (loadBubble) begin
      exValid     <= 1'b0;
      exCtrl      <= '0;
      exRs1       <= '0;
      exRs2       <= '0;
      exRd        <= '0;
      exReadData1 <= '0;
      exReadData2 <= '0;
      exImmExt    <= '0;
      exPc        <= '0;
    end else if (!bus.stallIn) begin
      exValid     <= bus.idValid;
      exCtrl      <= ctrlGate(idCtrl, bus.idValid);
      exRs1       <= bus.rs1;
      exRs2       <= bus.rs2;
      exRd        <= bus.rd;
      exReadData1 <= bus.readData1;
      exReadData2 <= bus.readData2;
      exImmExt    <= bus.immExt;
      exPc        <= bus.pc;
    end
  end

  // Count hazard bubbles only, saturating; flush bubbles are not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbleCnt <= '0;
    end else if (hazardBubble && (bubbleCnt != CNT_MAX)) begin
      bubbleCnt <= bubbleCnt + 1'b1;
    end
  end

  assign bus.exValid          = exValid;
  assign bus.exOpcode         = exCtrl.opcode;
  assign bus.exMultiDiv       = exCtrl.multiDiv;
  assign bus.exAluBType       = exCtrl.aluBType;
  assign bus.exAluSrc         = exCtrl.aluSrc;
  assign bus.exSignExtendFlag = exCtrl.signExtendFlag;
  assign bus.exMemRead        = exCtrl.memRead;
  assign bus.exMemToReg       = exCtrl.memToReg;
  assign bus.exMemWrite       = exCtrl.memWrite;
  assign bus.exAluControl     = exCtrl.aluControl;
  assign bus.exRegWrite       = exCtrl.regWrite;
  assign bus.exJumpBranch     = exCtrl.jumpBranch;
  assign bus.exRs1            = exRs1;
  assign bus.exRs2            = exRs2;
  assign bus.exRd             = exRd;
  assign bus.exReadData1      = exReadData1;
  assign bus.exReadData2      = exReadData2;
  assign bus.exImmExt         = exImmExt;
  assign bus.exPc             = exPc;
  assign bus.bubbleCount      = bubbleCnt;

endmodule
